// File: rtl/race_pkg.sv
// Shared race-game definitions: state encoding, winner codes, track boxes and BCD helper.
package race_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        READY     = 3'd1,
        COUNTDOWN = 3'd2,
        RACING    = 3'd4,
        FINISH    = 3'd5
    } race_state_e;

    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_P1   = 2'd1,
        WIN_P2   = 2'd2,
        WIN_TIE  = 2'd3
    } winner_e;

    localparam logic [9:0] FIN_X0_DEF = 10'd0;
    localparam logic [9:0] FIN_X1_DEF = 10'd40;
    localparam logic [9:0] FIN_Y0_DEF = 10'd115;
    localparam logic [9:0] FIN_Y1_DEF = 10'd135;
    localparam logic [9:0] CHK_X0_DEF = 10'd270;
    localparam logic [9:0] CHK_X1_DEF = 10'd319;
    localparam logic [9:0] CHK_Y0_DEF = 10'd100;
    localparam logic [9:0] CHK_Y1_DEF = 10'd140;

    localparam logic [15:0] TIME_MAX = 16'h9999;

    // Signed compare so a zero lower bound is not a constant-true unsigned test.
    function automatic logic in_box(input logic [9:0] x, input logic [9:0] y,
                                    input logic [9:0] x0, input logic [9:0] x1,
                                    input logic [9:0] y0, input logic [9:0] y1);
        return ($signed({1'b0, x}) >= $signed({1'b0, x0})) &&
               ($signed({1'b0, x}) <= $signed({1'b0, x1})) &&
               ($signed({1'b0, y}) >= $signed({1'b0, y0})) &&
               ($signed({1'b0, y}) <= $signed({1'b0, y1}));
    endfunction

    function automatic logic [15:0] bcd_inc(input logic [15:0] t);
        logic [15:0] r;
        logic        carry;
        r     = t;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/race_lap_tracker.sv
// Per-player lap counter: checkpoint arming, finish-line entry edge, saturating lap count.
module lap_tracker
    import race_pkg::*;
#(
    parameter int unsigned LAPS   = 3,
    parameter logic [9:0]  FIN_X0 = FIN_X0_DEF,
    parameter logic [9:0]  FIN_X1 = FIN_X1_DEF,
    parameter logic [9:0]  FIN_Y0 = FIN_Y0_DEF,
    parameter logic [9:0]  FIN_Y1 = FIN_Y1_DEF,
    parameter logic [9:0]  CHK_X0 = CHK_X0_DEF,
    parameter logic [9:0]  CHK_X1 = CHK_X1_DEF,
    parameter logic [9:0]  CHK_Y0 = CHK_Y0_DEF,
    parameter logic [9:0]  CHK_Y1 = CHK_Y1_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       enable,
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic [2:0] lap,
    output logic       done
);

    logic [9:0] x_q, y_q;
    logic       fin_prev_q, armed_q;
    logic [2:0] lap_q;
    logic       in_fin, in_chk, lap_inc;

    assign in_fin  = in_box(x_q, y_q, FIN_X0, FIN_X1, FIN_Y0, FIN_Y1);
    assign in_chk  = in_box(x_q, y_q, CHK_X0, CHK_X1, CHK_Y0, CHK_Y1);
    assign lap_inc = enable && in_fin && !fin_prev_q && armed_q && (lap_q != 3'(LAPS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q        <= '0;
            y_q        <= '0;
            fin_prev_q <= 1'b0;
            armed_q    <= 1'b0;
            lap_q      <= '0;
        end else begin
            x_q        <= x;
            y_q        <= y;
            // Edge history keeps running outside the race so the grid slot never looks like an entry.
            fin_prev_q <= clear ? 1'b0 : in_fin;
            if (clear) begin
                armed_q <= 1'b0;
                lap_q   <= '0;
            end else if (enable) begin
                if (lap_inc) begin
                    armed_q <= 1'b0;
                    lap_q   <= lap_q + 3'd1;
                end else if (in_chk) begin
                    armed_q <= 1'b1;
                end
            end
        end
    end

    assign lap  = lap_q;
    assign done = (lap_q == 3'(LAPS));

endmodule

// File: rtl/race_controller.sv
// Game-flow FSM and referee: start/ready handshake, countdown, race timer, lap/winner decision.
module race_controller
    import race_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 10_000_000,
    parameter int unsigned COUNT_TICKS = 10,
    parameter int unsigned LAPS        = 3,
    parameter logic [9:0]  FIN_X0      = FIN_X0_DEF,
    parameter logic [9:0]  FIN_X1      = FIN_X1_DEF,
    parameter logic [9:0]  FIN_Y0      = FIN_Y0_DEF,
    parameter logic [9:0]  FIN_Y1      = FIN_Y1_DEF,
    parameter logic [9:0]  CHK_X0      = CHK_X0_DEF,
    parameter logic [9:0]  CHK_X1      = CHK_X1_DEF,
    parameter logic [9:0]  CHK_Y0      = CHK_Y0_DEF,
    parameter logic [9:0]  CHK_Y1      = CHK_Y1_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        p1_honk,
    input  logic        p2_honk,
    input  logic [9:0]  p1_x,
    input  logic [9:0]  p1_y,
    input  logic [9:0]  p2_x,
    input  logic [9:0]  p2_y,
    output logic [2:0]  state,
    output logic [1:0]  countdown,
    output logic [2:0]  p1_lap,
    output logic [2:0]  p2_lap,
    output logic [1:0]  winner,
    output logic [15:0] time_bcd,
    output logic        p1_ready,
    output logic        p2_ready
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SW = (COUNT_TICKS > 1) ? $clog2(COUNT_TICKS) : 1;

    race_state_e state_q, state_d;
    winner_e     win_q, win_d;
    logic          start_q, start_rise;
    logic [1:0]    cd_q, cd_d;
    logic [15:0]   time_q, time_d;
    logic          p1r_q, p1r_d, p2r_q, p2r_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [SW-1:0] step_q, step_d;
    logic          tick, clear, track_en;
    logic          p1_done, p2_done;

    assign start_rise = start && !start_q;
    assign tick       = (tick_q == TW'(TICK_DIV - 1));
    // Trackers freeze once anyone is done so the winner matches the displayed laps.
    assign track_en   = (state_q == RACING) && !(p1_done || p2_done);

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        cd_d    = cd_q;
        time_d  = time_q;
        p1r_d   = p1r_q;
        p2r_d   = p2r_q;
        step_d  = step_q;
        clear   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_rise) state_d = READY;
            end
            READY: begin
                p1r_d = p1r_q || p1_honk;
                p2r_d = p2r_q || p2_honk;
                if (p1r_d && p2r_d) begin
                    state_d = COUNTDOWN;
                    clear   = 1'b1;
                    p1r_d   = 1'b0;
                    p2r_d   = 1'b0;
                    cd_d    = 2'd3;
                    step_d  = '0;
                    win_d   = WIN_NONE;
                    time_d  = '0;
                end
            end
            COUNTDOWN: begin
                if (tick) begin
                    if (step_q == SW'(COUNT_TICKS - 1)) begin
                        step_d = '0;
                        if (cd_q == 2'd1) begin
                            cd_d    = 2'd0;
                            state_d = RACING;
                        end else begin
                            cd_d = cd_q - 2'd1;
                        end
                    end else begin
                        step_d = step_q + SW'(1);
                    end
                end
            end
            RACING: begin
                if (p1_done || p2_done) begin
                    state_d = FINISH;
                    win_d   = (p1_done && p2_done) ? WIN_TIE : (p1_done ? WIN_P1 : WIN_P2);
                end else if (tick && (time_q != TIME_MAX)) begin
                    time_d = bcd_inc(time_q);
                end
            end
            FINISH: begin
                if (start_rise) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tick_d = '0;
        if ((state_d == state_q) && ((state_q == COUNTDOWN) || (state_q == RACING))) begin
            tick_d = tick ? '0 : tick_q + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            win_q   <= WIN_NONE;
            cd_q    <= '0;
            time_q  <= '0;
            p1r_q   <= 1'b0;
            p2r_q   <= 1'b0;
            tick_q  <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start;
            win_q   <= win_d;
            cd_q    <= cd_d;
            time_q  <= time_d;
            p1r_q   <= p1r_d;
            p2r_q   <= p2r_d;
            tick_q  <= tick_d;
            step_q  <= step_d;
        end
    end

    lap_tracker #(
        .LAPS(LAPS), .FIN_X0(FIN_X0), .FIN_X1(FIN_X1), .FIN_Y0(FIN_Y0), .FIN_Y1(FIN_Y1),
        .CHK_X0(CHK_X0), .CHK_X1(CHK_X1), .CHK_Y0(CHK_Y0), .CHK_Y1(CHK_Y1)
    ) u_p1_tracker (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .enable (track_en),
        .x      (p1_x),
        .y      (p1_y),
        .lap    (p1_lap),
        .done   (p1_done)
    );

    lap_tracker #(
        .LAPS(LAPS), .FIN_X0(FIN_X0), .FIN_X1(FIN_X1), .FIN_Y0(FIN_Y0), .FIN_Y1(FIN_Y1),
        .CHK_X0(CHK_X0), .CHK_X1(CHK_X1), .CHK_Y0(CHK_Y0), .CHK_Y1(CHK_Y1)
    ) u_p2_tracker (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .enable (track_en),
        .x      (p2_x),
        .y      (p2_y),
        .lap    (p2_lap),
        .done   (p2_done)
    );

    assign state     = state_q;
    assign countdown = cd_q;
    assign winner    = win_q;
    assign time_bcd  = time_q;
    assign p1_ready  = p1r_q;
    assign p2_ready  = p2r_q;

endmodule

// File: tb/tb_race_controller.sv
// Self-checking bench for race_controller against a cycle-count based game model.
module tb_race_controller;

    localparam int TD = 4;
    localparam int CT = 2;
    localparam int L  = 2;
    localparam int CD_CYCLES = 3 * CT * TD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, p1_honk = 1'b0, p2_honk = 1'b0;
    logic [9:0]  p1_x = '0, p1_y = '0, p2_x = '0, p2_y = '0;
    logic [2:0]  state, p1_lap, p2_lap;
    logic [1:0]  countdown, winner;
    logic [15:0] time_bcd;
    logic        p1_ready, p2_ready;
    logic [30:0] dut_outs;

    int total = 0;
    int bad   = 0;

    race_controller #(.TICK_DIV(TD), .COUNT_TICKS(CT), .LAPS(L)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .p1_honk   (p1_honk),
        .p2_honk   (p2_honk),
        .p1_x      (p1_x),
        .p1_y      (p1_y),
        .p2_x      (p2_x),
        .p2_y      (p2_y),
        .state     (state),
        .countdown (countdown),
        .p1_lap    (p1_lap),
        .p2_lap    (p2_lap),
        .winner    (winner),
        .time_bcd  (time_bcd),
        .p1_ready  (p1_ready),
        .p2_ready  (p2_ready)
    );

    always #5 clk = ~clk;

    assign dut_outs = {state, countdown, p1_lap, p2_lap, winner, time_bcd, p1_ready, p2_ready};

    // Model: game phase plus elapsed-cycle counts; countdown and timer derive from them.
    int m_state, m_cd_cyc, m_race_cyc, m_win;
    int m_lap[2];
    int m_x[2], m_y[2];
    bit m_armed[2], m_fprev[2];
    bit m_r1, m_r2, m_start_prev;

    function automatic bit is_fin(input int x, input int y);
        return x >= 0 && x <= 40 && y >= 115 && y <= 135;
    endfunction

    function automatic bit is_chk(input int x, input int y);
        return x >= 270 && x <= 319 && y >= 100 && y <= 140;
    endfunction

    function automatic logic [30:0] model_outs();
        int t, cd;
        logic [15:0] tb;
        t  = m_race_cyc / TD;
        if (t > 9999) t = 9999;
        tb = {4'(t / 1000), 4'((t / 100) % 10), 4'((t / 10) % 10), 4'(t % 10)};
        cd = (m_state == 2) ? 3 - m_cd_cyc / (CT * TD) : 0;
        return {3'(m_state), 2'(cd), 3'(m_lap[0]), 3'(m_lap[1]), 2'(m_win), tb, m_r1, m_r2};
    endfunction

    task automatic model_reset();
        m_state = 0; m_cd_cyc = 0; m_race_cyc = 0; m_win = 0;
        m_r1 = 0; m_r2 = 0; m_start_prev = 0;
        for (int p = 0; p < 2; p++) begin
            m_lap[p] = 0; m_x[p] = 0; m_y[p] = 0; m_armed[p] = 0; m_fprev[p] = 0;
        end
    endtask

    task automatic model_edge();
        bit rise, clr, active, inf, inc;
        int ns;
        rise   = start && !m_start_prev;
        ns     = m_state;
        clr    = 0;
        active = (m_state == 4) && (m_lap[0] != L) && (m_lap[1] != L);
        case (m_state)
            0: if (rise) ns = 1;
            1: begin
                m_r1 = m_r1 | p1_honk;
                m_r2 = m_r2 | p2_honk;
                if (m_r1 && m_r2) begin ns = 2; clr = 1; end
            end
            2: begin
                m_cd_cyc++;
                if (m_cd_cyc == CD_CYCLES) ns = 4;
            end
            4: begin
                if (!active) begin
                    ns    = 5;
                    m_win = (m_lap[0] == L && m_lap[1] == L) ? 3 : ((m_lap[0] == L) ? 1 : 2);
                end else begin
                    m_race_cyc++;
                end
            end
            5: if (rise) ns = 0;
            default: ns = 0;
        endcase
        for (int p = 0; p < 2; p++) begin
            inf = is_fin(m_x[p], m_y[p]);
            inc = is_chk(m_x[p], m_y[p]);
            if (clr) begin
                m_lap[p] = 0; m_armed[p] = 0; m_fprev[p] = 0;
            end else begin
                if (active) begin
                    if (inf && !m_fprev[p] && m_armed[p] && m_lap[p] < L) begin
                        m_lap[p]++;
                        m_armed[p] = 0;
                    end else if (inc) begin
                        m_armed[p] = 1;
                    end
                end
                m_fprev[p] = inf;
            end
        end
        m_x[0] = int'(p1_x); m_y[0] = int'(p1_y);
        m_x[1] = int'(p2_x); m_y[1] = int'(p2_y);
        if (clr) begin
            m_r1 = 0; m_r2 = 0; m_win = 0; m_race_cyc = 0; m_cd_cyc = 0;
        end
        m_state      = ns;
        m_start_prev = start;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        #1;
    endtask

    // kind 0: finish box, 1: checkpoint box, otherwise open track.
    task automatic pick(input int kind, output logic [9:0] x, output logic [9:0] y);
        case (kind)
            0: begin x = 10'($urandom_range(0, 40));    y = 10'($urandom_range(115, 135)); end
            1: begin x = 10'($urandom_range(270, 319)); y = 10'($urandom_range(100, 140)); end
            default: begin x = 10'($urandom_range(60, 250)); y = 10'($urandom_range(0, 479)); end
        endcase
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        total++;
        if (dut_outs !== 31'd0) begin
            bad++; $display("FAIL reset_outs: got %h want %h", dut_outs, 31'd0);
        end
        rst = 1'b0;
        step();
        total++;
        if (dut_outs !== model_outs()) begin
            bad++; $display("FAIL reset_idle: got %h want %h", dut_outs, model_outs());
        end
    endtask

    task automatic test_start();
        int rises = 0;
        logic [2:0] prev;
        prev  = state;
        start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (prev == 3'd0 && state == 3'd1) rises++;
            prev = state;
            total++;
            if (dut_outs !== model_outs()) begin
                bad++; $display("FAIL start_cyc%0d: got %h want %h", i, dut_outs, model_outs());
            end
        end
        start = 1'b0;
        total++;
        if (rises != 1 || state !== 3'd1) begin
            bad++; $display("FAIL start_once: got rises=%0d state=%0d want 1/1", rises, state);
        end
    endtask

    task automatic test_ready_countdown();
        p1_x = 10'd15; p1_y = 10'd125; p2_x = 10'd15; p2_y = 10'd120;
        repeat ($urandom_range(1, 4)) step();
        p1_honk = 1'b1; step(); p1_honk = 1'b0;
        total++;
        if (p1_ready !== 1'b1 || p2_ready !== 1'b0 || state !== 3'd1) begin
            bad++; $display("FAIL ready_p1: got r1=%b r2=%b st=%0d want 1/0/1", p1_ready,
                            p2_ready, state);
        end
        repeat (5) step();
        p2_honk = 1'b1; step(); p2_honk = 1'b0;
        total++;
        if (state !== 3'd2 || countdown !== 2'd3) begin
            bad++; $display("FAIL cd_entry: got st=%0d cd=%0d want 2/3", state, countdown);
        end
        for (int i = 0; i < CD_CYCLES; i++) begin
            total++;
            if (state !== 3'd2 || countdown !== 2'(3 - i / (CT * TD)) ||
                dut_outs !== model_outs()) begin
                bad++; $display("FAIL cd_cyc%0d: got %h want %h", i, dut_outs, model_outs());
            end
            step();
        end
        total++;
        if (state !== 3'd4 || countdown !== 2'd0 || dut_outs !== model_outs()) begin
            bad++; $display("FAIL race_entry: got %h want %h", dut_outs, model_outs());
        end
    endtask

    task automatic test_laps();
        int kinds[5]   = '{1, 0, 2, 0, 0};
        int exp_lap[5] = '{0, 1, 1, 1, 1};
        logic [9:0] x, y;
        pick(2, x, y); p2_x = x; p2_y = y;
        repeat (3) step();
        total++;
        if (p1_lap !== 3'd0 || dut_outs !== model_outs()) begin
            bad++; $display("FAIL grid_no_lap: got %h want %h", dut_outs, model_outs());
        end
        for (int i = 0; i < 5; i++) begin
            pick(kinds[i], x, y);
            if (i == 1) begin x = 10'd15; y = 10'd125; end
            if (i != 4) begin p1_x = x; p1_y = y; end
            repeat (3) step();
            total++;
            if (p1_lap !== 3'(exp_lap[i]) || dut_outs !== model_outs()) begin
                bad++; $display("FAIL laps_wp%0d: got %h lap=%0d want %h lap=%0d", i, dut_outs,
                                p1_lap, model_outs(), exp_lap[i]);
            end
        end
    endtask

    task automatic test_finish();
        logic [9:0] x, y;
        logic [15:0] saved;
        pick(1, x, y); p1_x = x; p1_y = y;
        pick(1, x, y); p2_x = x; p2_y = y;
        repeat ($urandom_range(3, 9)) step();
        pick(0, x, y); p1_x = x; p1_y = y;
        repeat (4) step();
        total++;
        if (state !== 3'd5 || winner !== 2'd1 || p1_lap !== 3'd2 || dut_outs !== model_outs())
        begin
            bad++; $display("FAIL finish_p1: got %h want %h", dut_outs, model_outs());
        end
        saved = time_bcd;
        pick(0, x, y); p2_x = x; p2_y = y;
        repeat (3 * TD) step();
        total++;
        if (time_bcd !== saved || p2_lap !== 3'd0 || dut_outs !== model_outs()) begin
            bad++; $display("FAIL finish_hold: got %h want %h", dut_outs, model_outs());
        end
        start = 1'b1; step(); start = 1'b0; step();
        total++;
        if (state !== 3'd0 || p1_lap !== 3'd2 || winner !== 2'd1 || time_bcd !== saved) begin
            bad++; $display("FAIL finish_to_idle: got st=%0d lap=%0d win=%0d t=%h want 0/2/1/%h",
                            state, p1_lap, winner, time_bcd, saved);
        end
    endtask

    task automatic enter_race(input bit same_cycle);
        start = 1'b1; step(); start = 1'b0;
        if (same_cycle) begin
            p1_honk = 1'b1; p2_honk = 1'b1; step(); p1_honk = 1'b0; p2_honk = 1'b0;
        end else begin
            p2_honk = 1'b1; step(); p2_honk = 1'b0; step();
            p1_honk = 1'b1; step(); p1_honk = 1'b0;
        end
        repeat (CD_CYCLES) step();
    endtask

    task automatic test_tie();
        logic [9:0] x, y;
        bit swap;
        enter_race(1'b1);
        total++;
        if (state !== 3'd4 || dut_outs !== model_outs()) begin
            bad++; $display("FAIL tie_race_entry: got %h want %h", dut_outs, model_outs());
        end
        swap = 1'($urandom_range(0, 1));
        for (int k = 0; k < 4; k++) begin
            pick((k < 2) ? 1 : 0, x, y);
            if ((k % 2 == 0) ^ swap) begin p1_x = x; p1_y = y; end
            else begin p2_x = x; p2_y = y; end
            repeat ($urandom_range(3, 5)) step();
        end
        total++;
        if (p1_lap !== 3'd1 || p2_lap !== 3'd1 || dut_outs !== model_outs()) begin
            bad++; $display("FAIL tie_lap1: got %h want %h", dut_outs, model_outs());
        end
        pick(1, x, y); p1_x = x; p1_y = y;
        pick(1, x, y); p2_x = x; p2_y = y;
        repeat (3) step();
        pick(2, x, y); p1_x = x; p1_y = y;
        pick(2, x, y); p2_x = x; p2_y = y;
        repeat ($urandom_range(2, 6)) step();
        pick(0, x, y); p1_x = x; p1_y = y;
        pick(0, x, y); p2_x = x; p2_y = y;
        repeat (4) step();
        total++;
        if (winner !== 2'd3 || state !== 3'd5 || dut_outs !== model_outs()) begin
            bad++; $display("FAIL tie_winner: got %h want %h", dut_outs, model_outs());
        end
    endtask

    task automatic test_saturation_reset();
        logic [9:0] x, y;
        start = 1'b1; step(); start = 1'b0; step();
        pick(2, x, y); p1_x = x; p1_y = y;
        pick(2, x, y); p2_x = x; p2_y = y;
        enter_race(1'b0);
        for (int i = 0; i < 41; i++) begin
            repeat (1000) step();
            total++;
            if (dut_outs !== model_outs()) begin
                bad++; $display("FAIL timer_k%0d: got %h want %h", i, dut_outs, model_outs());
            end
        end
        total++;
        if (time_bcd !== 16'h9999 || state !== 3'd4) begin
            bad++; $display("FAIL timer_sat: got t=%h st=%0d want 9999/4", time_bcd, state);
        end
        rst = 1'b1;
        #1;
        model_reset();
        total++;
        if (dut_outs !== 31'd0) begin
            bad++; $display("FAIL async_rst: got %h want %h", dut_outs, 31'd0);
        end
        step();
        rst = 1'b0;
        step();
        total++;
        if (dut_outs !== model_outs()) begin
            bad++; $display("FAIL post_rst: got %h want %h", dut_outs, model_outs());
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_start();
        test_ready_countdown();
        test_laps();
        test_finish();
        test_tie();
        test_saturation_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/race_controller.md
Name: race_controller

Overview:
- Game-flow FSM and race referee for the two-player split-screen racer.
- Produces the 3-bit `state` bus consumed by OperationEncoder and both PhysicsEngine instances.
- Consumes world positions from both PhysicsEngines and honk bits from OperationEncoder.
- Outputs lap counts, countdown value, winner and a BCD race timer for the HUD and SevenSegment.

Parameters:
- TICK_DIV, 10_000_000: clk cycles per 0.1 s tick (100 MHz).
- COUNT_TICKS, 10: ticks per countdown step (1 s).
- LAPS, 3: laps required to finish, range 1..7.
- FIN_X0/FIN_X1/FIN_Y0/FIN_Y1, 0/40/115/135: finish-line box, world pixels, inclusive.
- CHK_X0/CHK_X1/CHK_Y0/CHK_Y1, 270/319/100/140: checkpoint box, inclusive.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level from keyboard (Enter); internally rising-edge detected.
- p1_honk  in  1  P1 honk level.
- p2_honk  in  1  P2 honk level.
- p1_x, p1_y  in  10 each  P1 world position.
- p2_x, p2_y  in  10 each  P2 world position.
- state  out  3  encoding: IDLE=0, READY=1, COUNTDOWN=2, RACING=4, FINISH=5.
- countdown  out  2  3/2/1 during COUNTDOWN, otherwise 0.
- p1_lap  out  3  P1 completed laps.
- p2_lap  out  3  P2 completed laps.
- winner  out  2  0 none, 1 P1, 2 P2, 3 tie.
- time_bcd  out  16  race time as BCD SSS.t: [15:12] hundreds, [11:8] tens, [7:4] units, [3:0] tenths.
- p1_ready  out  1  P1 ready latch.
- p2_ready  out  1  P2 ready latch.

Behaviour:
- Reset: state=IDLE, countdown=0, laps=0, winner=0, time_bcd=0, ready latches=0, tick counter=0, all edge-detect registers=0.
- All outputs are registered and update on the clk edge after the causing input.
- IDLE -> READY on a start rising edge.
  - start held high produces one event only.
- READY:
  - p1_ready and p2_ready are sticky; each sets on its honk=1.
  - When both latches are 1 -> COUNTDOWN.
  - The transition may occur in the same cycle both are seen.
  - Entering COUNTDOWN clears laps, winner, time_bcd, the tick counter, both trackers and both ready latches.
- COUNTDOWN:
  - countdown=3 on entry.
  - Decrements every COUNT_TICKS ticks: 3 -> 2 -> 1.
  - After the step at value 1 expires -> RACING with countdown=0.
  - Total duration is 3*COUNT_TICKS*TICK_DIV cycles.
- Tick generator:
  - Counter 0..TICK_DIV-1; runs only in COUNTDOWN and RACING.
  - Reset to 0 on each state entry.
  - Pulse fires when the counter = TICK_DIV-1.
- Race timer (RACING only):
  - time_bcd increments by one tenth per tick, with BCD carry 9 -> 0 per digit.
  - Saturates at 999.9 (16'h9999).
  - Frozen in every other state; retained through FINISH.
- Lap tracking, one tracker per player, using registered positions:
  - in_chk and in_fin are inclusive box tests.
  - armed sets while in_chk=1 and clears on lap increment.
  - A lap increments when in_fin rises (previous=0, current=1) and armed=1.
  - Trackers are active only in RACING.
  - The fin-edge register is cleared on COUNTDOWN entry and tracked continuously.
  - The grid start position sits inside the finish box; it never counts, because armed=0.
  - Lap saturates at LAPS.
- Finish:
  - The first cycle in which either lap reaches LAPS sets winner (1 or 2) -> FINISH.
  - Both reaching LAPS in the same cycle sets winner=3.
  - In FINISH, laps, winner and time_bcd are held; a start rising edge -> IDLE.
- Illegal encodings (3, 6, 7) -> IDLE on the next cycle.
- rst mid-operation: immediate return to all reset values.

Decomposition:
- Shared package `race_pkg`:
  - state encoding constants (IDLE, READY, COUNTDOWN, RACING, FINISH), also to be used by OperationEncoder and PhysicsEngine in place of the literal 3'd4;
  - winner codes;
  - box-bound defaults.
- One sub-module `lap_tracker`, instantiated twice:
  - ports: clk, rst, clear, enable, x, y, box parameters, lap[2:0], done;
  - contains the box compare, armed flag, edge detect and saturating lap counter.

Test Plan (TICK_DIV=4, COUNT_TICKS=2, LAPS=2):
1. Reset and start sequence:
   - Stimulus: rst pulse, then start high for 10 cycles.
   - Required: state 0 -> 1 exactly once; no further advance while start stays high.
2. Ready and countdown:
   - Stimulus: p1_honk pulse, then 5 cycles later p2_honk.
   - Required: p1_ready=1 first; state=2 the cycle after p2_ready is seen.
   - countdown shows 3, 2, 1 for 8 cycles each; then state=4, countdown=0.
3. Lap counting:
   - Stimulus: P1 moves (15,125) -> (300,120) -> (15,125).
   - Required: p1_lap=1.
   - Re-entering the finish box without visiting the checkpoint: no increment.
   - Staying inside the finish box: no increment.
4. Finish and timer freeze:
   - Stimulus: P1 completes 2 laps before P2.
   - Required: winner=1, state=5, time_bcd frozen at its last value.
   - A start edge then gives state=0 with lap, winner and time values retained.
5. Tie:
   - Stimulus: P1 and P2 enter the finish box armed on lap 2 in the same cycle.
   - Required: winner=3.
6. Timer saturation and async reset:
   - Stimulus: force 999.9 in RACING (or run long), then assert rst mid-RACING.
   - Required: time_bcd holds at 16'h9999; on rst, all outputs clear asynchronously without waiting for a clk edge.
